// File: rtl/zynq_mac_accel.sv
// Paired-stream multiply-accumulate core sitting between the PL shell FIFOs.
// Consumes len (A,B) pairs per job, emits the wrapped 32-bit sum, reports state/done count.
module zynq_mac_accel #(
  parameter int data_width_p     = 32,
  parameter int len_width_p      = 16,
  parameter int done_cnt_width_p = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [data_width_p-1:0] cfg_len_i,
  input  logic                    cfg_start_i,
  input  logic [data_width_p-1:0] a_data_i,
  input  logic                    a_v_i,
  output logic                    a_yumi_o,
  input  logic [data_width_p-1:0] b_data_i,
  input  logic                    b_v_i,
  output logic                    b_yumi_o,
  output logic [data_width_p-1:0] res_data_o,
  output logic                    res_v_o,
  input  logic                    res_ready_i,
  output logic [data_width_p-1:0] status_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [data_width_p-1:0]     acc_q, acc_d;
  logic [len_width_p-1:0]      cnt_q, cnt_d;
  logic [len_width_p-1:0]      len_q, len_d;
  logic [done_cnt_width_p-1:0] done_q, done_d;

  logic                    fire;
  logic [data_width_p-1:0] prod;
  logic [len_width_p-1:0]  start_len;
  logic [15:0]             done_field;
  logic                    cfg_len_unused;

  assign start_len      = cfg_len_i[len_width_p-1:0];
  assign cfg_len_unused = ^cfg_len_i[data_width_p-1:len_width_p];

  // Product is evaluated at the accumulator width, so only the low bits survive.
  assign prod = a_data_i * b_data_i;

  assign fire     = (state_q == RUN) & a_v_i & b_v_i;
  assign a_yumi_o = fire;
  assign b_yumi_o = fire;

  assign res_v_o    = (state_q == EMIT);
  assign res_data_o = res_v_o ? acc_q : '0;
  assign done_field = 16'(done_q);

  always_comb begin
    status_o        = '0;
    status_o[1:0]   = state_q;
    status_o[2]     = (state_q != IDLE);
    status_o[31:16] = done_field;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          len_d   = start_len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (start_len != '0) ? RUN : EMIT;
        end
      end
      RUN: begin
        if (fire) begin
          acc_d = acc_q + prod;
          cnt_d = cnt_q + len_width_p'(1);
          if (cnt_q == len_q - len_width_p'(1)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (res_ready_i) begin
          state_d = IDLE;
          done_d  = done_q + done_cnt_width_p'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

endmodule
